// File: rtl/hc32_tester.sv
// Stimulus/response tester for the hc32 quad-OR gate: sweeps {a,b}, samples out after a settle delay, counts mismatches.
// Optional first-failure capture is enabled by defining HC32_TESTER_FAILLOG_EN.
//
// state  | meaning
// IDLE   | waiting for start, a=b=0
// DRIVE  | present vector vec on a/b, load settle counter
// SETTLE | wait SETTLE_CYCLES for the gate to settle
// CHECK  | compare dut_out with a|b, advance vector/loop
// DONE   | report pass/err_cnt, hold last vector, wait for restart

module hc32_tester #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned LOOPS         = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic       dut_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_cnt,
    output logic [1:0] fail_vec,
    output logic       fail_valid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYCLES);
    localparam logic [7:0] LAST_LOOP = 8'(LOOPS - 1);

    state_t     state_q, state_d;
    logic [1:0] vec_q, vec_d;
    logic [7:0] loop_q, loop_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] err_q, err_d;
    logic       a_q, a_d;
    logic       b_q, b_d;
    logic       mismatch;

    assign mismatch = (state_q == S_CHECK) && (dut_out != (a_q | b_q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            vec_q   <= 2'd0;
            loop_q  <= 8'd0;
            cnt_q   <= 8'd0;
            err_q   <= 8'd0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            loop_q  <= loop_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        loop_d  = loop_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        a_d     = a_q;
        b_d     = b_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_DRIVE;
                    vec_d   = 2'd0;
                    loop_d  = 8'd0;
                    err_d   = 8'd0;
                end
            end
            S_DRIVE: begin
                a_d     = vec_q[1];
                b_d     = vec_q[0];
                cnt_d   = SETTLE_LD;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q <= 8'd1) begin
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_CHECK: begin
                if (mismatch && (err_q != 8'hFF)) begin
                    err_d = err_q + 8'd1;
                end
                if (vec_q == 2'd3) begin
                    if (loop_q == LAST_LOOP) begin
                        state_d = S_DONE;
                    end else begin
                        loop_d  = loop_q + 8'd1;
                        vec_d   = 2'd0;
                        state_d = S_DRIVE;
                    end
                end else begin
                    vec_d   = vec_q + 2'd1;
                    state_d = S_DRIVE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign a       = a_q;
    assign b       = b_q;
    assign busy    = (state_q == S_DRIVE) || (state_q == S_SETTLE) || (state_q == S_CHECK);
    assign done    = (state_q == S_DONE);
    assign pass    = (state_q == S_DONE) && (err_q == 8'd0);
    assign err_cnt = err_q;

`ifdef HC32_TESTER_FAILLOG_EN
    logic [1:0] fail_vec_q;
    logic       fail_valid_q;
    logic       clr_log;

    assign clr_log = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    // Only the first mismatch of a run is kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_vec_q   <= 2'b00;
            fail_valid_q <= 1'b0;
        end else if (clr_log) begin
            fail_vec_q   <= 2'b00;
            fail_valid_q <= 1'b0;
        end else if (mismatch && !fail_valid_q) begin
            fail_vec_q   <= {a_q, b_q};
            fail_valid_q <= 1'b1;
        end
    end

    assign fail_vec   = fail_vec_q;
    assign fail_valid = fail_valid_q;
`else
    assign fail_vec   = 2'b00;
    assign fail_valid = 1'b0;
`endif

endmodule

// File: tb/tb_hc32_tester.sv
// Directed bench for hc32_tester: three instances (defaults, SETTLE_CYCLES=1, LOOPS=100) with selectable good/stuck gate models.
module tb_hc32_tester;

`ifdef HC32_TESTER_FAILLOG_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif

    logic clk = 1'b0;
    logic clk_run = 1'b0;
    logic rst = 1'b1;
    logic [2:0] start_v = 3'b000;
    logic [1:0] mode [3];  // 0 good, 1 stuck-at-0, 2 stuck-at-1

    logic       a_o [3];
    logic       b_o [3];
    logic       dout [3];
    logic       busy_o [3];
    logic       done_o [3];
    logic       pass_o [3];
    logic [7:0] err_o [3];
    logic [1:0] fv_o [3];
    logic       fval_o [3];

    int checks = 0;
    int failures = 0;
    int sel = 0;

    always #5 if (clk_run) clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_gate
        assign dout[g] = (mode[g] == 2'd0) ? (a_o[g] | b_o[g]) :
                         (mode[g] == 2'd1) ? 1'b0 : 1'b1;
    end

    hc32_tester u_def (
        .clk(clk), .rst(rst), .start(start_v[0]), .a(a_o[0]), .b(b_o[0]),
        .dut_out(dout[0]), .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]),
        .err_cnt(err_o[0]), .fail_vec(fv_o[0]), .fail_valid(fval_o[0]));

    hc32_tester #(.SETTLE_CYCLES(1)) u_s1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .a(a_o[1]), .b(b_o[1]),
        .dut_out(dout[1]), .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]),
        .err_cnt(err_o[1]), .fail_vec(fv_o[1]), .fail_valid(fval_o[1]));

    hc32_tester #(.LOOPS(100)) u_l100 (
        .clk(clk), .rst(rst), .start(start_v[2]), .a(a_o[2]), .b(b_o[2]),
        .dut_out(dout[2]), .busy(busy_o[2]), .done(done_o[2]), .pass(pass_o[2]),
        .err_cnt(err_o[2]), .fail_vec(fv_o[2]), .fail_valid(fval_o[2]));

    typedef struct {
        string    name;
        int       inst;
        logic [1:0] md;
        int       done_edge;
        int       err;
        bit       pass;
        logic [1:0] fv;
        bit       fval;
    } scn_t;

    scn_t scn [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic run_scn(input scn_t s);
        int de;
        de = -1;
        mode[s.inst] = s.md;
        @(negedge clk);
        start_v[s.inst] = 1'b1;
        @(posedge clk);
        #1;
        start_v[s.inst] = 1'b0;
        chk({s.name, "_busy_e0"}, 32'(busy_o[s.inst]), 32'd1);
        for (int n = 1; n <= 3000; n++) begin
            @(posedge clk);
            #1;
            if (done_o[s.inst]) begin
                de = n;
                break;
            end
        end
        chk({s.name, "_done_edge"}, 32'(de), 32'(s.done_edge));
        chk({s.name, "_err_cnt"}, 32'(err_o[s.inst]), 32'(s.err));
        chk({s.name, "_pass"}, 32'(pass_o[s.inst]), 32'(s.pass));
        chk({s.name, "_fail_vec"}, 32'(fv_o[s.inst]), FL ? 32'(s.fv) : 32'd0);
        chk({s.name, "_fail_valid"}, 32'(fval_o[s.inst]), FL ? 32'(s.fval) : 32'd0);
        chk({s.name, "_ab_last"}, 32'({a_o[s.inst], b_o[s.inst]}), 32'd3);
    endtask

    initial begin
        int k;
        logic [3:0] exp4;
        mode[0] = 2'd0; mode[1] = 2'd0; mode[2] = 2'd0;

        scn[0] = '{"def_good",   0, 2'd0, 24,   0,   1'b1, 2'b00, 1'b0};
        scn[1] = '{"def_sa0",    0, 2'd1, 24,   3,   1'b0, 2'b01, 1'b1};
        scn[2] = '{"def_sa1",    0, 2'd2, 24,   1,   1'b0, 2'b00, 1'b1};
        scn[3] = '{"s1_sa1",     1, 2'd2, 12,   1,   1'b0, 2'b00, 1'b1};
        scn[4] = '{"s1_good",    1, 2'd0, 12,   0,   1'b1, 2'b00, 1'b0};
        scn[5] = '{"l100_sa0",   2, 2'd1, 2400, 255, 1'b0, 2'b01, 1'b1};

        // Reset with no clock running.
        #2;
        chk("rst_ab", 32'({a_o[0], b_o[0]}), 32'd0);
        chk("rst_busy", 32'(busy_o[0]), 32'd0);
        chk("rst_done", 32'(done_o[0]), 32'd0);
        chk("rst_pass", 32'(pass_o[0]), 32'd0);
        chk("rst_err", 32'(err_o[0]), 32'd0);
        chk("rst_fval", 32'(fval_o[0]), 32'd0);

        clk_run = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Good default sweep with a stray start while busy at edge 7.
        sel = 0;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        chk("sweep_e0", 32'({a_o[0], b_o[0], busy_o[0], done_o[0]}), 32'b0010);
        for (int n = 1; n <= 24; n++) begin
            if (n == 7) start_v[0] = 1'b1;
            @(posedge clk);
            #1;
            start_v[0] = 1'b0;
            k = (n - 1) / 6;
            exp4 = {k[1:0], (n < 24) ? 1'b1 : 1'b0, (n == 24) ? 1'b1 : 1'b0};
            chk($sformatf("sweep_e%0d", n), 32'({a_o[0], b_o[0], busy_o[0], done_o[0]}), 32'(exp4));
        end
        chk("sweep_pass", 32'(pass_o[0]), 32'd1);
        chk("sweep_err", 32'(err_o[0]), 32'd0);
        @(posedge clk);
        #1;
        chk("sweep_done_hold", 32'({done_o[0], pass_o[0], a_o[0], b_o[0]}), 32'b1111);

        for (int i = 0; i < 6; i++) run_scn(scn[i]);

        // Reset mid-sweep at edge 10 (stuck-at-1 so a mismatch is already logged).
        mode[0] = 2'd2;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk);
            #1;
        end
        chk("mid_ab_e10", 32'({a_o[0], b_o[0]}), 32'd1);
        chk("mid_err_e10", 32'(err_o[0]), 32'd1);
        chk("mid_fval_e10", 32'(fval_o[0]), FL ? 32'd1 : 32'd0);
        rst = 1'b1;
        #1;
        chk("mid_rst_ab", 32'({a_o[0], b_o[0]}), 32'd0);
        chk("mid_rst_busy", 32'(busy_o[0]), 32'd0);
        chk("mid_rst_done_pass", 32'({done_o[0], pass_o[0]}), 32'd0);
        chk("mid_rst_err", 32'(err_o[0]), 32'd0);
        chk("mid_rst_fail", 32'({fv_o[0], fval_o[0]}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_scn('{"after_rst", 0, 2'd0, 24, 0, 1'b1, 2'b00, 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hc32_tester.md
# hc32_tester

Self-checking stimulus/response stage for the hc32 quad-OR model. It sits directly upstream of the gate, driving its `a`/`b` inputs through every input combination. It also sits directly downstream, sampling the gate's `out` after a settle delay and comparing it with the expected OR result. It then reports pass/fail and an error count to the board-level bring-up logic on the SmartFusion2 target.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 4: clock cycles between driving a vector and sampling the gate output. Legal range 1..255.
- `LOOPS`, default 1: number of full 4-vector sweeps per start. Legal range 1..255.

Ports:
- `clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- `rst`: input, 1 bit. Asynchronous, active-high reset.
- `start`: input, 1 bit. Begins a test run; sampled only in IDLE or DONE.
- `a`: output, 1 bit. Drives gate input a (registered).
- `b`: output, 1 bit. Drives gate input b (registered).
- `dut_out`: input, 1 bit. The gate's `out`.
- `busy`: output, 1 bit. High from start acceptance until DONE.
- `done`: output, 1 bit. High while in DONE.
- `pass`: output, 1 bit. High in DONE when `err_cnt==0`; 0 otherwise.
- `err_cnt`: output, 8 bits. Mismatch count, saturating at 255.
- `fail_vec`: output, 2 bits. First failing vector {a,b}; only meaningful with the fail-log feature.
- `fail_valid`: output, 1 bit. A failure has been logged.

## Operation
- The FSM has five states: IDLE, DRIVE, SETTLE, CHECK, DONE.
- Vector index `vec` is 2 bits, with a=`vec[1]` and b=`vec[0]`. The sweep order is 00, 01, 10, 11.
- IDLE:
  - Outputs: a=b=0, busy=0.
  - `start`=1 moves to DRIVE. On that transition: vec=0, loop=0, err_cnt=0, fail_valid=0, fail_vec=0, busy=1.
- DRIVE: registers a/b from vec, loads the settle counter with SETTLE_CYCLES, then goes to SETTLE.
- SETTLE: decrements the counter each cycle and moves to CHECK when the counter reaches 1. The state therefore occupies exactly SETTLE_CYCLES cycles.
- CHECK: compares `dut_out` with a|b.
  - On mismatch, err_cnt increments; at 255 it holds.
  - Then:
    - If vec=3 and loop=LOOPS-1, go to DONE.
    - Else if vec=3, set loop+1, vec=0, and go to DRIVE.
    - Else set vec+1 and go to DRIVE.
- DONE:
  - done=1, busy=0, pass=(err_cnt==0).
  - a/b hold the last vector (11).
  - err_cnt, fail_vec and fail_valid hold.
  - `start`=1 restarts exactly as from IDLE.
- `start` is ignored in DRIVE, SETTLE and CHECK.
- `a`/`b` change only on the DRIVE→SETTLE edge, or to 0 on reset.

## Timing
- Call the edge at which `start` is sampled high edge 0.
  - busy=1 after edge 0.
  - a/b take vector 0 after edge 1.
- Each vector takes SETTLE_CYCLES+2 cycles: DRIVE 1, SETTLE SETTLE_CYCLES, CHECK 1.
- The vector i CHECK decision occurs at edge (i+1)(SETTLE_CYCLES+2), counting vectors across loops.
- DONE is entered at edge 4·LOOPS·(SETTLE_CYCLES+2). With the defaults that is edge 24.
- `dut_out` is sampled only in CHECK, so the combinational gate has SETTLE_CYCLES+1 full cycles to settle.
- Reset behaviour: `rst` high at any time, including mid-sweep, immediately forces:
  - state=IDLE
  - a=b=0, busy=0, done=0, pass=0
  - err_cnt=0, fail_vec=0, fail_valid=0
- Operation resumes on the first rising edge after `rst` falls.
- Saturation: when err_cnt=255 and another mismatch occurs, err_cnt stays 255 and pass stays 0.

## Configuration
- `HC32_TESTER_FAILLOG_EN` defined:
  - On the first CHECK mismatch of a run, fail_vec={a,b} and fail_valid=1.
  - Later mismatches do not overwrite them. They clear on start acceptance or reset.
- Not defined: fail_vec=0 and fail_valid=0 constantly, and the capture registers are removed. All other behaviour is unchanged.

## Test plan
- Reset check: assert `rst` with no clock running. Required: a=b=0, busy=done=pass=0, err_cnt=0, fail_valid=0.
- Good DUT (dut_out=a|b), defaults, pulse `start` at edge 0:
  - a/b sequence 00, 01, 10, 11, each held 6 cycles.
  - done=1 after edge 24, pass=1, err_cnt=0, fail_valid=0.
- Stuck-at-0 DUT, defaults: err_cnt=3, pass=0. With FAILLOG_EN: fail_vec=01, fail_valid=1.
- Stuck-at-1 DUT, SETTLE_CYCLES=1: done after edge 12, err_cnt=1, pass=0, fail_vec=00 (with FAILLOG_EN).
- Stuck-at-0 DUT, LOOPS=100: 300 mismatches occur, err_cnt saturates at 255, pass=0.
- Control robustness:
  - `start` pulsed while busy has no effect; timing is unchanged.
  - `rst` asserted at edge 10 gives immediate reset values.
  - A new `start` after reset produces a full 24-cycle sweep with pass=1 on a good DUT.
